// File: rtl/apb_gpio_core.sv
// APB-attached GPIO block: pad output/enable registers, synchronised inputs and
// per-pin edge interrupts with a single level IRQ output.
module apb_gpio_core #(
   parameter int GPIO_W = 32
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   input  logic              PSEL,
   input  logic              PENABLE,
   input  logic              PWRITE,
   input  logic [31:0]       PADDR,
   input  logic [31:0]       PWDATA,
   output logic [31:0]       PRDATA,
   output logic              PREADY,
   output logic              IRQ,
   input  logic [GPIO_W-1:0] gpio_in,
   output logic [GPIO_W-1:0] gpio_out,
   output logic [GPIO_W-1:0] gpio_oe
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   localparam logic [5:0] OFF_IN    = 6'h00;
   localparam logic [5:0] OFF_OUT   = 6'h01;
   localparam logic [5:0] OFF_OE    = 6'h02;
   localparam logic [5:0] OFF_INTE  = 6'h03;
   localparam logic [5:0] OFF_PTRIG = 6'h04;
   localparam logic [5:0] OFF_INTS  = 6'h05;
   localparam logic [5:0] OFF_CTRL  = 6'h06;

   state_t            state;
   state_t            state_nxt;
   logic [5:0]        offset;
   logic              rd_en;
   logic              wr_en;
   logic [31:0]       rd_mux;
   logic [GPIO_W-1:0] out_r;
   logic [GPIO_W-1:0] oe_r;
   logic [GPIO_W-1:0] inte_r;
   logic [GPIO_W-1:0] ptrig_r;
   logic [GPIO_W-1:0] ints_r;
   logic              ctrl_ie;
   logic [GPIO_W-1:0] s1;
   logic [GPIO_W-1:0] s2;
   logic [GPIO_W-1:0] p;
   logic [GPIO_W-1:0] edge_det;
   logic [GPIO_W-1:0] w1c;
   logic              unused_bits;

   assign offset      = PADDR[7:2];
   assign unused_bits = ^{PADDR[31:8], PADDR[1:0], PWDATA};

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) state <= IDLE;
      else          state <= state_nxt;
   end

   // An enable seen without a preceding setup phase never leaves IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (PSEL && !PENABLE) state_nxt = SETUP;
         SETUP: begin
            if (PSEL && PENABLE) state_nxt = ACCESS;
            else if (!PSEL)      state_nxt = IDLE;
         end
         ACCESS:  state_nxt = (PSEL && !PENABLE) ? SETUP : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      PREADY = (state == ACCESS);
      rd_en  = (state == SETUP) && PSEL && PENABLE && !PWRITE;
      wr_en  = (state == ACCESS) && PWRITE;
   end

   always_comb begin
      rd_mux = '0;
      case (offset)
         OFF_IN:    rd_mux[GPIO_W-1:0] = s2;
         OFF_OUT:   rd_mux[GPIO_W-1:0] = out_r;
         OFF_OE:    rd_mux[GPIO_W-1:0] = oe_r;
         OFF_INTE:  rd_mux[GPIO_W-1:0] = inte_r;
         OFF_PTRIG: rd_mux[GPIO_W-1:0] = ptrig_r;
         OFF_INTS:  rd_mux[GPIO_W-1:0] = ints_r;
         OFF_CTRL:  rd_mux[0]          = ctrl_ie;
         default:   rd_mux             = '0;
      endcase
   end

   always_comb begin
      edge_det = (ptrig_r & s2 & ~p) | (~ptrig_r & ~s2 & p);
      w1c      = (wr_en && offset == OFF_INTS) ? PWDATA[GPIO_W-1:0] : '0;
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) PRDATA <= '0;
      else if (rd_en) PRDATA <= rd_mux;
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         out_r   <= '0;
         oe_r    <= '0;
         inte_r  <= '0;
         ptrig_r <= '0;
         ctrl_ie <= 1'b0;
      end else if (wr_en) begin
         case (offset)
            OFF_OUT:   out_r   <= PWDATA[GPIO_W-1:0];
            OFF_OE:    oe_r    <= PWDATA[GPIO_W-1:0];
            OFF_INTE:  inte_r  <= PWDATA[GPIO_W-1:0];
            OFF_PTRIG: ptrig_r <= PWDATA[GPIO_W-1:0];
            OFF_CTRL:  ctrl_ie <= PWDATA[0];
            default:   ;
         endcase
      end
   end

   // A new edge wins over a write-one-to-clear landing on the same clock.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         s1     <= '0;
         s2     <= '0;
         p      <= '0;
         ints_r <= '0;
         IRQ    <= 1'b0;
      end else begin
         s1     <= gpio_in;
         s2     <= s1;
         p      <= s2;
         ints_r <= (ints_r & ~w1c) | (edge_det & inte_r);
         IRQ    <= ctrl_ie & (|ints_r);
      end
   end

   assign gpio_out = out_r;
   assign gpio_oe  = oe_r;

endmodule
